// File: rtl/insn_encoder_if.sv
// Symbolic-instruction input channel, memory write channel and status of the encoder.
// The encoder connects through the slave modport; the loader/bench drives the master side.
interface insn_encoder_if #(
  parameter int ADDR_WIDTH = 6
) ();
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_mnem;
  logic [4:0]            in_rs;
  logic [4:0]            in_rt;
  logic [4:0]            in_rd;
  logic [4:0]            in_shamt;
  logic [15:0]           in_imm;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  err;

  modport master (
    output start, in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data, count, full, err
  );

  modport slave (
    input  start, in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data, count, full, err
  );
endinterface

// File: rtl/insn_encoder.sv
// Encodes symbolic MIPS-subset instructions into 32-bit words and streams them to
// instruction memory at consecutive word addresses, stopping once the memory is full.
module insn_encoder #(
  parameter int ADDR_WIDTH = 6,
  parameter int BASE_ADDR  = 0
) (
  input logic           clk,
  input logic           rst,
  insn_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   CAP  = {1'b1, {ADDR_WIDTH{1'b0}}};

  function automatic logic is_legal(input logic [3:0] mnem);
    return (mnem <= 4'd13);
  endfunction

  // Shifts force rs=0; other R-types force shamt=0; I-types ignore rd/shamt.
  function automatic logic [31:0] encode(
    input logic [3:0]  mnem,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm
  );
    logic [31:0] word;
    word = 32'h0000_0000;
    case (mnem)
      4'd0:    word = {6'h00, 5'd0, rt, rd, shamt, 6'h00};
      4'd1:    word = {6'h00, 5'd0, rt, rd, shamt, 6'h02};
      4'd2:    word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd3:    word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'd4:    word = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      4'd5:    word = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4'd6:    word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      4'd7:    word = {6'h08, rs, rt, imm};
      4'd8:    word = {6'h0C, rs, rt, imm};
      4'd9:    word = {6'h0D, rs, rt, imm};
      4'd10:   word = {6'h23, rs, rt, imm};
      4'd11:   word = {6'h2B, rs, rt, imm};
      4'd12:   word = {6'h04, rs, rt, imm};
      4'd13:   word = {6'h05, rs, rt, imm};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  state_e                state_q, state_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  err_q, err_d;
  logic                  in_ready_s;
  logic                  xfer_s;
  logic                  wr_done_s;

  // Next-state logic: start overrides everything, then write completion, then a new transfer.
  always_comb begin
    state_d    = state_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    count_d    = count_q;
    err_d      = err_q;
    in_ready_s = (state_q == ST_RUN) && (!wr_valid_q || bus.wr_ready);
    xfer_s     = bus.in_valid && in_ready_s;
    wr_done_s  = wr_valid_q && bus.wr_ready;
    if (bus.start) begin
      state_d    = ST_RUN;
      wr_valid_d = 1'b0;
      wr_addr_d  = BASE;
      count_d    = '0;
      err_d      = 1'b0;
    end else begin
      if (wr_done_s) begin
        wr_addr_d  = wr_addr_q + ADDR_WIDTH'(1);
        count_d    = count_q + (ADDR_WIDTH + 1)'(1);
        wr_valid_d = 1'b0;
      end else begin
        wr_valid_d = wr_valid_q;
      end
      if (xfer_s && is_legal(bus.in_mnem)) begin
        wr_valid_d = 1'b1;
        wr_data_d  = encode(bus.in_mnem, bus.in_rs, bus.in_rt, bus.in_rd,
                            bus.in_shamt, bus.in_imm);
      end else if (xfer_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      // The last word fills memory; anything accepted alongside it would wrap, so drop it.
      if (wr_done_s && (count_d == CAP)) begin
        state_d    = ST_FULL;
        wr_valid_d = 1'b0;
      end else begin
        state_d = state_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= BASE;
      wr_data_q  <= 32'h0000_0000;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.count    = count_q;
  assign bus.full     = (state_q == ST_FULL);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Directed bench for insn_encoder: a 64-word instance for encoding/flow control and a
// 4-word instance for the full condition.
module tb_insn_encoder;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  insn_encoder_if #(.ADDR_WIDTH(6)) bus_a ();
  insn_encoder_if #(.ADDR_WIDTH(2)) bus_b ();

  insn_encoder #(.ADDR_WIDTH(6), .BASE_ADDR(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  insn_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct packed {
    logic [3:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] word;
  } vec_t;

  // Hand-encoded reference vectors; I-types carry junk rd/shamt that must be ignored.
  function automatic vec_t get_vec(input int i);
    vec_t v;
    case (i)
      0:  v = '{4'd7,  5'd0,  5'd5,  5'd31, 5'd31, 16'hFFFF, 32'h2005FFFF};
      1:  v = '{4'd10, 5'd29, 5'd4,  5'd31, 5'd31, 16'h0008, 32'h8FA40008};
      2:  v = '{4'd0,  5'd7,  5'd1,  5'd2,  5'd4,  16'hBEEF, 32'h00011100};
      3:  v = '{4'd1,  5'd31, 5'd7,  5'd6,  5'd31, 16'h0000, 32'h000737C2};
      4:  v = '{4'd3,  5'd2,  5'd3,  5'd1,  5'd5,  16'h0000, 32'h00430822};
      5:  v = '{4'd4,  5'd5,  5'd6,  5'd4,  5'd0,  16'h0000, 32'h00A62024};
      6:  v = '{4'd5,  5'd8,  5'd9,  5'd7,  5'd0,  16'h0000, 32'h01093825};
      7:  v = '{4'd6,  5'd11, 5'd12, 5'd10, 5'd0,  16'h0000, 32'h016C502A};
      8:  v = '{4'd8,  5'd1,  5'd2,  5'd31, 5'd31, 16'h00FF, 32'h302200FF};
      9:  v = '{4'd9,  5'd3,  5'd4,  5'd31, 5'd31, 16'h1234, 32'h34641234};
      10: v = '{4'd11, 5'd29, 5'd31, 5'd31, 5'd31, 16'hFFFC, 32'hAFBFFFFC};
      11: v = '{4'd12, 5'd1,  5'd2,  5'd31, 5'd31, 16'h0003, 32'h10220003};
      12: v = '{4'd13, 5'd3,  5'd0,  5'd31, 5'd31, 16'hFFFE, 32'h1460FFFE};
      13: v = '{4'd2,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 32'h00221820};
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.in_valid = 1'b1;
    bus_a.in_mnem  = v.mnem;
    bus_a.in_rs    = v.rs;
    bus_a.in_rt    = v.rt;
    bus_a.in_rd    = v.rd;
    bus_a.in_shamt = v.shamt;
    bus_a.in_imm   = v.imm;
  endtask

  task automatic drive_b(input vec_t v);
    bus_b.in_valid = 1'b1;
    bus_b.in_mnem  = v.mnem;
    bus_b.in_rs    = v.rs;
    bus_b.in_rt    = v.rt;
    bus_b.in_rd    = v.rd;
    bus_b.in_shamt = v.shamt;
    bus_b.in_imm   = v.imm;
  endtask

  task automatic start_a();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
  endtask

  task automatic start_b();
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.wr_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.wr_ready = 1'b1; bus_b.in_valid = 1'b0;
    bus_b.in_mnem = 4'd0; bus_b.in_rs = 5'd0; bus_b.in_rt = 5'd0; bus_b.in_rd = 5'd0;
    bus_b.in_shamt = 5'd0; bus_b.in_imm = 16'h0000;
    drive_a(get_vec(13));
    step();
    step();
    checks++; if (bus_a.wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", bus_a.wr_valid); end
    checks++; if (bus_a.wr_addr !== 6'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", bus_a.wr_addr); end
    checks++; if (bus_a.wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", bus_a.wr_data); end
    checks++; if (bus_a.count !== 7'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus_a.count); end
    checks++; if (bus_a.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus_a.full); end
    checks++; if (bus_a.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus_a.err); end
    checks++; if (bus_a.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus_a.in_ready); end
    rst = 1'b0;
    step();
    checks++; if (bus_a.in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready got=%b exp=0", bus_a.in_ready); end
    checks++; if (bus_a.wr_valid !== 1'b0) begin failures++; $display("FAIL idle_wr_valid got=%b exp=0", bus_a.wr_valid); end
    bus_a.in_valid = 1'b0;
  endtask

  task automatic test_add();
    bus_a.wr_ready = 1'b1;
    start_a();
    checks++; if (bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready got=%b exp=1", bus_a.in_ready); end
    drive_a(get_vec(13));
    step();
    bus_a.in_valid = 1'b0;
    checks++; if (bus_a.wr_valid !== 1'b1) begin failures++; $display("FAIL add_wr_valid got=%b exp=1", bus_a.wr_valid); end
    checks++; if (bus_a.wr_data !== 32'h00221820) begin failures++; $display("FAIL add_wr_data got=%h exp=00221820", bus_a.wr_data); end
    checks++; if (bus_a.wr_addr !== 6'd0) begin failures++; $display("FAIL add_wr_addr got=%0d exp=0", bus_a.wr_addr); end
    step();
    checks++; if (bus_a.count !== 7'd1) begin failures++; $display("FAIL add_count got=%0d exp=1", bus_a.count); end
    checks++; if (bus_a.wr_valid !== 1'b0) begin failures++; $display("FAIL add_wr_valid_after got=%b exp=0", bus_a.wr_valid); end
    checks++; if (bus_a.wr_addr !== 6'd1) begin failures++; $display("FAIL add_next_addr got=%0d exp=1", bus_a.wr_addr); end
  endtask

  task automatic test_encode();
    vec_t v;
    bus_a.wr_ready = 1'b1;
    start_a();
    for (int i = 0; i < 13; i++) begin
      v = get_vec(i);
      drive_a(v);
      step();
      checks++; if (bus_a.wr_valid !== 1'b1) begin failures++; $display("FAIL encode_valid[%0d] got=%b exp=1", i, bus_a.wr_valid); end
      checks++; if (bus_a.wr_data !== v.word) begin failures++; $display("FAIL encode_data[%0d] got=%h exp=%h", i, bus_a.wr_data, v.word); end
      checks++; if (bus_a.wr_addr !== 6'(i)) begin failures++; $display("FAIL encode_addr[%0d] got=%0d exp=%0d", i, bus_a.wr_addr, i); end
    end
    bus_a.in_valid = 1'b0;
    step();
    checks++; if (bus_a.count !== 7'd13) begin failures++; $display("FAIL encode_count got=%0d exp=13", bus_a.count); end
    checks++; if (bus_a.wr_valid !== 1'b0) begin failures++; $display("FAIL encode_idle_valid got=%b exp=0", bus_a.wr_valid); end
  endtask

  task automatic test_back_to_back();
    bus_a.wr_ready = 1'b1;
    start_a();
    bus_a.wr_ready = 1'b0;
    drive_a(get_vec(13));
    step();
    drive_a(get_vec(9));
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus_a.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", k, bus_a.in_ready); end
      checks++; if (bus_a.wr_valid !== 1'b1 || bus_a.wr_data !== 32'h00221820 || bus_a.wr_addr !== 6'd0) begin
        failures++; $display("FAIL stall_hold[%0d] got=%b/%h/%0d exp=1/00221820/0", k, bus_a.wr_valid, bus_a.wr_data, bus_a.wr_addr);
      end
      step();
    end
    bus_a.wr_ready = 1'b1;
    #1;
    checks++; if (bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", bus_a.in_ready); end
    step();
    bus_a.in_valid = 1'b0;
    checks++; if (bus_a.wr_valid !== 1'b1 || bus_a.wr_data !== 32'h34641234 || bus_a.wr_addr !== 6'd1) begin
      failures++; $display("FAIL b2b_second got=%b/%h/%0d exp=1/34641234/1", bus_a.wr_valid, bus_a.wr_data, bus_a.wr_addr);
    end
    checks++; if (bus_a.count !== 7'd1) begin failures++; $display("FAIL b2b_count1 got=%0d exp=1", bus_a.count); end
    step();
    checks++; if (bus_a.count !== 7'd2 || bus_a.wr_valid !== 1'b0) begin failures++; $display("FAIL b2b_count2 got=%0d/%b exp=2/0", bus_a.count, bus_a.wr_valid); end
  endtask

  task automatic test_illegal();
    vec_t v;
    bus_a.wr_ready = 1'b1;
    start_a();
    v = get_vec(13);
    v.mnem = 4'd15;
    drive_a(v);
    checks++; if (bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL illegal_in_ready got=%b exp=1", bus_a.in_ready); end
    step();
    checks++; if (bus_a.wr_valid !== 1'b0 || bus_a.err !== 1'b1) begin failures++; $display("FAIL illegal15 valid/err got=%b/%b exp=0/1", bus_a.wr_valid, bus_a.err); end
    v.mnem = 4'd14;
    drive_a(v);
    step();
    checks++; if (bus_a.wr_valid !== 1'b0 || bus_a.wr_addr !== 6'd0) begin failures++; $display("FAIL illegal14 valid/addr got=%b/%0d exp=0/0", bus_a.wr_valid, bus_a.wr_addr); end
    drive_a(get_vec(11));
    step();
    bus_a.in_valid = 1'b0;
    checks++; if (bus_a.wr_valid !== 1'b1 || bus_a.wr_data !== 32'h10220003 || bus_a.wr_addr !== 6'd0) begin
      failures++; $display("FAIL illegal_next got=%b/%h/%0d exp=1/10220003/0", bus_a.wr_valid, bus_a.wr_data, bus_a.wr_addr);
    end
    checks++; if (bus_a.err !== 1'b1) begin failures++; $display("FAIL illegal_sticky got=%b exp=1", bus_a.err); end
    step();
    checks++; if (bus_a.count !== 7'd1) begin failures++; $display("FAIL illegal_count got=%0d exp=1", bus_a.count); end
    start_a();
    checks++; if (bus_a.err !== 1'b0 || bus_a.count !== 7'd0) begin failures++; $display("FAIL start_clears got=%b/%0d exp=0/0", bus_a.err, bus_a.count); end
  endtask

  task automatic test_start_drop();
    bus_a.wr_ready = 1'b1;
    start_a();
    bus_a.wr_ready = 1'b0;
    drive_a(get_vec(7));
    step();
    bus_a.start = 1'b1;
    drive_a(get_vec(9));
    step();
    bus_a.start = 1'b0;
    bus_a.in_valid = 1'b0;
    checks++; if (bus_a.wr_valid !== 1'b0 || bus_a.wr_addr !== 6'd0 || bus_a.count !== 7'd0) begin
      failures++; $display("FAIL start_stalled got=%b/%0d/%0d exp=0/0/0", bus_a.wr_valid, bus_a.wr_addr, bus_a.count);
    end
    bus_a.wr_ready = 1'b1;
    drive_a(get_vec(5));
    step();
    bus_a.start = 1'b1;
    drive_a(get_vec(6));
    step();
    bus_a.start = 1'b0;
    bus_a.in_valid = 1'b0;
    checks++; if (bus_a.wr_valid !== 1'b0 || bus_a.wr_addr !== 6'd0 || bus_a.count !== 7'd0) begin
      failures++; $display("FAIL start_priority got=%b/%0d/%0d exp=0/0/0", bus_a.wr_valid, bus_a.wr_addr, bus_a.count);
    end
    step();
    checks++; if (bus_a.wr_valid !== 1'b0) begin failures++; $display("FAIL start_dropped_xfer got=%b exp=0", bus_a.wr_valid); end
  endtask

  task automatic test_rst_drop();
    vec_t v;
    bus_a.wr_ready = 1'b1;
    start_a();
    bus_a.wr_ready = 1'b0;
    v = get_vec(13);
    v.mnem = 4'd14;
    drive_a(v);
    step();
    drive_a(get_vec(13));
    step();
    bus_a.in_valid = 1'b0;
    checks++; if (bus_a.wr_valid !== 1'b1 || bus_a.err !== 1'b1) begin failures++; $display("FAIL pre_rst got=%b/%b exp=1/1", bus_a.wr_valid, bus_a.err); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus_a.wr_valid !== 1'b0 || bus_a.wr_data !== 32'h0 || bus_a.wr_addr !== 6'd0) begin
      failures++; $display("FAIL rst_drop_word got=%b/%h/%0d exp=0/0/0", bus_a.wr_valid, bus_a.wr_data, bus_a.wr_addr);
    end
    checks++; if (bus_a.err !== 1'b0 || bus_a.count !== 7'd0 || bus_a.in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_drop_state got=%b/%0d/%b exp=0/0/0", bus_a.err, bus_a.count, bus_a.in_ready);
    end
  endtask

  task automatic test_full();
    vec_t v;
    bus_b.wr_ready = 1'b1;
    start_b();
    for (int i = 0; i < 4; i++) begin
      v = get_vec(i);
      drive_b(v);
      step();
      checks++; if (bus_b.wr_data !== v.word || bus_b.wr_addr !== 2'(i)) begin
        failures++; $display("FAIL full_fill[%0d] got=%h/%0d exp=%h/%0d", i, bus_b.wr_data, bus_b.wr_addr, v.word, i);
      end
    end
    bus_b.in_valid = 1'b0;
    step();
    checks++; if (bus_b.full !== 1'b1 || bus_b.count !== 3'd4) begin failures++; $display("FAIL full_flag got=%b/%0d exp=1/4", bus_b.full, bus_b.count); end
    drive_b(get_vec(8));
    checks++; if (bus_b.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", bus_b.in_ready); end
    step();
    checks++; if (bus_b.wr_valid !== 1'b0 || bus_b.count !== 3'd4) begin failures++; $display("FAIL full_blocks got=%b/%0d exp=0/4", bus_b.wr_valid, bus_b.count); end
    start_b();
    checks++; if (bus_b.full !== 1'b0 || bus_b.count !== 3'd0 || bus_b.wr_addr !== 2'd0 || bus_b.in_ready !== 1'b1) begin
      failures++; $display("FAIL full_restart got=%b/%0d/%0d/%b exp=0/0/0/1", bus_b.full, bus_b.count, bus_b.wr_addr, bus_b.in_ready);
    end
    step();
    bus_b.in_valid = 1'b0;
    checks++; if (bus_b.wr_valid !== 1'b1 || bus_b.wr_data !== 32'h302200FF || bus_b.wr_addr !== 2'd0) begin
      failures++; $display("FAIL full_rewrite got=%b/%h/%0d exp=1/302200FF/0", bus_b.wr_valid, bus_b.wr_data, bus_b.wr_addr);
    end
    step();
    checks++; if (bus_b.count !== 3'd1) begin failures++; $display("FAIL full_recount got=%0d exp=1", bus_b.count); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_encode();
    test_back_to_back();
    test_illegal();
    test_start_drop();
    test_rst_drop();
    test_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
